clause_event_collector: RTL
===========================

# clause_event_collector

Sits at the output side of the clause array and consumes the per-clause terminal drive lines: implication, conflict, satisfied and max level. On a start strobe it snapshots all NUM_C clause lines, then reports the resulting events to the BCP/conflict-analysis controller over a valid/ready channel, one event per handshake. Conflict has priority over everything else. Implications are drained lowest clause index first, and the block reports an all-satisfied or no-event outcome when that applies.

## Interface
Parameters:
- NUM_C, 8: number of clauses in the array.
- WIDTH_LVL, 16: decision-level width.
- WIDTH_CID, 3: clause-index width; must satisfy 2^WIDTH_CID ≥ NUM_C.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request to snapshot the terminal lines and report; honoured only in IDLE.
- imp_drv_i  in  NUM_C  per-clause implication drive.
- conflict_c_drv_i  in  NUM_C  per-clause conflict drive.
- csat_drv_i  in  NUM_C  per-clause satisfied drive.
- cmax_lvl_i  in  NUM_C*WIDTH_LVL  per-clause max level; clause k occupies [k*WIDTH_LVL +: WIDTH_LVL].
- busy_o  out  1  high from start acceptance until done_o, inclusive.
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts the event.
- evt_type_o  out  2  event type: 0 IMPLY, 1 CONFLICT, 2 ALLSAT, 3 NONE.
- evt_cid_o  out  WIDTH_CID  clause index; 0 for ALLSAT and NONE.
- evt_lvl_o  out  WIDTH_LVL  cmax_lvl of the reported clause; 0 for ALLSAT and NONE.
- done_o  out  1  one-cycle pulse when the report sequence completes.

## Operation
- States: IDLE, EVAL, EMIT, DONE.
- IDLE → EVAL on start_i. Snapshot registers capture conf_s, sat_s, lvl_s and pend_s = imp_drv_i & ~csat_drv_i. A clause that is already satisfied never implies.
- EVAL loads the first event, in priority order, and moves to EMIT:
  - any conf_s bit: CONFLICT, lowest set index;
  - else sat_s all ones: ALLSAT;
  - else any pend_s bit: IMPLY, lowest set index;
  - else: NONE.
- EMIT, on a handshake (evt_valid_o & evt_ready_i):
  - for CONFLICT, ALLSAT or NONE: go to DONE; remaining pending implications are discarded;
  - for IMPLY: clear the reported bit in pend_s;
    - if bits remain, load the next lowest-index IMPLY in the same edge (no bubble);
    - otherwise go to DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- start_i outside IDLE is ignored. Terminal inputs are not observed outside the start cycle.
- Only one conflict is ever reported per sequence: the lowest index wins.

## Timing
- Reset (asynchronous, rst = 0), all outputs and state cleared:
  - state → IDLE;
  - busy_o, evt_valid_o, done_o, evt_type_o, evt_cid_o, evt_lvl_o → 0;
  - snapshots → 0.
- Reset mid-sequence aborts immediately. No done_o is produced for the aborted sequence.
- Latency: start_i sampled at edge t → evt_valid_o high after edge t+1.
- Handshake rules:
  - evt_valid_o never depends combinationally on evt_ready_i;
  - while valid & !ready, all evt_* outputs hold stable.
- Throughput: one IMPLY per cycle with evt_ready_i held high.
- done_o is asserted the cycle after the last handshake. busy_o falls with the IDLE return.
- All outputs are registered.

## Structure
- Package sat_event_pkg holds:
  - the evt_type enum (EVT_IMPLY, EVT_CONFLICT, EVT_ALLSAT, EVT_NONE);
  - the state enum;
  - NUM_C / WIDTH_CID consistency constants.
- Sub-module clause_prio_enc: parameterised lowest-index priority encoder.
  - Input: an NUM_C-bit mask.
  - Outputs: any, index.
  - Instantiate once for the conflict mask and once for the pending mask. For next-implication lookahead, the pending-mask instance is driven with pend_s minus the reported bit.

## Test plan
- Conflict priority: NUM_C=8; conflict on clauses 5 and 2; imp on 1; cmax_lvl[2]=7. Required: a single event CONFLICT, cid 2, lvl 7, then done_o.
- Implication drain, ready held high:
  - stimulus: imp=8'b1010_0100, csat=0, levels k+10;
  - required: IMPLY events with cid 2/lvl 12, cid 5/lvl 15, cid 7/lvl 17 on consecutive cycles, then done_o.
- Backpressure and filtering:
  - stimulus: imp=8'b0000_0011, csat=8'b0000_0001, evt_ready_i low for 4 cycles;
  - required: IMPLY cid 1 held stable for those 4 cycles; cid 0 never reported.
- Outcome types: csat=8'hFF → ALLSAT, cid 0, lvl 0. All inputs 0 → NONE. Each is followed by done_o.
- Start-while-busy and reset:
  - a start_i pulse during EMIT is ignored, and the event sequence is unchanged;
  - rst low mid-drain drops all outputs to 0 asynchronously; no done_o follows;
  - a start after release operates normally.

Source files
------------

// File: rtl/sat_event_pkg.sv
// Shared types for the clause event collector: event codes, FSM states and
// the clause-count / clause-index width defaults.
package sat_event_pkg;

  typedef enum logic [1:0] {
    EVT_IMPLY    = 2'd0,
    EVT_CONFLICT = 2'd1,
    EVT_ALLSAT   = 2'd2,
    EVT_NONE     = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StEmit = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned NumCDefault     = 8;
  localparam int unsigned WidthCidDefault = 3;

  // A clause index must be able to address every clause in the array.
  function automatic bit cid_width_ok(int unsigned num_c, int unsigned width_cid);
    return width_cid >= $clog2(num_c);
  endfunction

endpackage

// File: rtl/clause_prio_enc.sv
// Lowest-index-first priority encoder over a clause mask.
module clause_prio_enc #(
  parameter int unsigned NUM_C     = 8,
  parameter int unsigned WIDTH_CID = 3
) (
  input  logic [NUM_C-1:0]     mask_i,
  output logic                 any_o,
  output logic [WIDTH_CID-1:0] idx_o
);

  always_comb begin
    any_o = |mask_i;
    idx_o = '0;
    // Scan downwards so the lowest set bit is the last (winning) assignment.
    for (int i = NUM_C - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = WIDTH_CID'(i);
      end
    end
  end

endmodule

// File: rtl/clause_event_collector.sv
// Snapshots the clause array terminal lines on start and reports conflict,
// all-satisfied, implication or no-event outcomes over a valid/ready channel.
module clause_event_collector
  import sat_event_pkg::*;
#(
  parameter int unsigned NUM_C     = NumCDefault,
  parameter int unsigned WIDTH_LVL = 16,
  parameter int unsigned WIDTH_CID = WidthCidDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [NUM_C-1:0]           imp_drv_i,
  input  logic [NUM_C-1:0]           conflict_c_drv_i,
  input  logic [NUM_C-1:0]           csat_drv_i,
  input  logic [NUM_C*WIDTH_LVL-1:0] cmax_lvl_i,
  output logic                       busy_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [1:0]                 evt_type_o,
  output logic [WIDTH_CID-1:0]       evt_cid_o,
  output logic [WIDTH_LVL-1:0]       evt_lvl_o,
  output logic                       done_o
);

  if (!cid_width_ok(NUM_C, WIDTH_CID)) begin : gen_cfg_err
    $error("WIDTH_CID too narrow for NUM_C");
  end

  state_e                     state_q, state_d;
  logic [NUM_C-1:0]           conf_q, conf_d;
  logic [NUM_C-1:0]           sat_q, sat_d;
  logic [NUM_C-1:0]           pend_q, pend_d;
  logic [NUM_C*WIDTH_LVL-1:0] lvl_q, lvl_d;
  logic                       busy_q, busy_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  evt_type_e                  type_q, type_d;
  logic [WIDTH_CID-1:0]       cid_q, cid_d;
  logic [WIDTH_LVL-1:0]       elvl_q, elvl_d;

  logic [NUM_C-1:0]     clr_mask, pend_look;
  logic                 conf_any, pend_any;
  logic [WIDTH_CID-1:0] conf_idx, pend_idx;
  logic [WIDTH_LVL-1:0] conf_lvl, pend_lvl;
  logic                 hs;

  // While an implication is on the channel, look ahead past it so the next
  // one can be loaded on the same handshake edge.
  always_comb begin
    clr_mask = '0;
    if (state_q == StEmit && type_q == EVT_IMPLY) begin
      clr_mask[cid_q] = 1'b1;
    end
  end

  assign pend_look = pend_q & ~clr_mask;

  clause_prio_enc #(
    .NUM_C     (NUM_C),
    .WIDTH_CID (WIDTH_CID)
  ) u_conf_enc (
    .mask_i (conf_q),
    .any_o  (conf_any),
    .idx_o  (conf_idx)
  );

  clause_prio_enc #(
    .NUM_C     (NUM_C),
    .WIDTH_CID (WIDTH_CID)
  ) u_pend_enc (
    .mask_i (pend_look),
    .any_o  (pend_any),
    .idx_o  (pend_idx)
  );

  assign conf_lvl = lvl_q[int'(conf_idx)*WIDTH_LVL +: WIDTH_LVL];
  assign pend_lvl = lvl_q[int'(pend_idx)*WIDTH_LVL +: WIDTH_LVL];
  assign hs       = valid_q & evt_ready_i;

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    sat_d   = sat_q;
    pend_d  = pend_q;
    lvl_d   = lvl_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = done_q;
    type_d  = type_q;
    cid_d   = cid_q;
    elvl_d  = elvl_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          conf_d  = conflict_c_drv_i;
          sat_d   = csat_drv_i;
          pend_d  = imp_drv_i & ~csat_drv_i;
          lvl_d   = cmax_lvl_i;
          busy_d  = 1'b1;
          state_d = StEval;
        end
      end
      StEval: begin
        valid_d = 1'b1;
        state_d = StEmit;
        if (conf_any) begin
          type_d = EVT_CONFLICT;
          cid_d  = conf_idx;
          elvl_d = conf_lvl;
        end else if (&sat_q) begin
          type_d = EVT_ALLSAT;
          cid_d  = '0;
          elvl_d = '0;
        end else if (pend_any) begin
          type_d = EVT_IMPLY;
          cid_d  = pend_idx;
          elvl_d = pend_lvl;
        end else begin
          type_d = EVT_NONE;
          cid_d  = '0;
          elvl_d = '0;
        end
      end
      StEmit: begin
        if (hs) begin
          if (type_q == EVT_IMPLY) begin
            pend_d = pend_look;
          end
          if (type_q == EVT_IMPLY && pend_any) begin
            cid_d  = pend_idx;
            elvl_d = pend_lvl;
          end else begin
            valid_d = 1'b0;
            type_d  = EVT_IMPLY;
            cid_d   = '0;
            elvl_d  = '0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      conf_q  <= '0;
      sat_q   <= '0;
      pend_q  <= '0;
      lvl_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      type_q  <= EVT_IMPLY;
      cid_q   <= '0;
      elvl_q  <= '0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      sat_q   <= sat_d;
      pend_q  <= pend_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      type_q  <= type_d;
      cid_q   <= cid_d;
      elvl_q  <= elvl_d;
    end
  end

  assign busy_o      = busy_q;
  assign evt_valid_o = valid_q;
  assign evt_type_o  = type_q;
  assign evt_cid_o   = cid_q;
  assign evt_lvl_o   = elvl_q;
  assign done_o      = done_q;

endmodule
